// File: rtl/hdmi_tx_encode_multi.sv
// ---------------------------------------------------------------------------
// hdmi_tx_encode_multi
//   NUM_CH-lane TMDS encoder for the HDMI/DVI transmit path, placed between
//   timing/packet generation and the 10:1 serializers. Each lane codes one
//   10-bit symbol per pixel clock in one of five shared period modes:
//   control, video (8b10b TMDS with DC balance), data island (TERC4),
//   video guard band and data-island guard band. All lanes share a fixed
//   five-stage pipeline, so every lane emits its symbol on the same clock.
//
// Parameters
//   NUM_CH   number of TMDS lanes (1..8); guard-band codes use lane i mod 3
//   HDMI_EN  0 builds a DVI-only encoder: modes 2..4 are coded as control
//
// Ports
//   clk       pixel clock
//   reset     asynchronous, active-high reset
//   cke       pipeline advance enable; every register holds while low
//   in_mode   0=CTRL 1=VIDEO 2=DATA_ISLAND 3=VID_GB 4=DI_GB, 5..7 illegal
//   in_d      video byte per lane,    lane i = in_d[8i+7:8i]
//   in_c      control {c1,c0} per lane, lane i = in_c[2i+1:2i]
//   in_aux    TERC4 nibble per lane,  lane i = in_aux[4i+3:4i]
//   out_d     TMDS symbol per lane,   lane i = out_d[10i+9:10i], bit0 first
//   out_mode  in_mode aligned with out_d
//   out_err   sticky flag, set once an illegal mode reaches the output
// ---------------------------------------------------------------------------
module hdmi_tx_encode_multi #(
    parameter int NUM_CH  = 3,
    parameter int HDMI_EN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cke,
    input  logic [2:0]            in_mode,
    input  logic [8*NUM_CH-1:0]   in_d,
    input  logic [2*NUM_CH-1:0]   in_c,
    input  logic [4*NUM_CH-1:0]   in_aux,
    output logic [10*NUM_CH-1:0]  out_d,
    output logic [2:0]            out_mode,
    output logic                  out_err
);

    localparam logic [2:0] MODE_CTRL   = 3'd0;
    localparam logic [2:0] MODE_VIDEO  = 3'd1;
    localparam logic [2:0] MODE_DI     = 3'd2;
    localparam logic [2:0] MODE_VID_GB = 3'd3;
    localparam logic [2:0] MODE_DI_GB  = 3'd4;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] GB_A    = 10'b1011001100;
    localparam logic [9:0] GB_B    = 10'b0100110011;

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] sym;
        case (c)
            2'b00:   sym = 10'b1101010100;
            2'b01:   sym = 10'b0010101011;
            2'b10:   sym = 10'b0101010100;
            default: sym = 10'b1010101011;
        endcase
        return sym;
    endfunction

    function automatic logic [9:0] terc4_code(input logic [3:0] nib);
        logic [9:0] sym;
        case (nib)
            4'h0:    sym = 10'b1010011100;
            4'h1:    sym = 10'b1001100011;
            4'h2:    sym = 10'b1011100100;
            4'h3:    sym = 10'b1011100010;
            4'h4:    sym = 10'b0101110001;
            4'h5:    sym = 10'b0100011110;
            4'h6:    sym = 10'b0110001110;
            4'h7:    sym = 10'b0100111100;
            4'h8:    sym = 10'b1011001100;
            4'h9:    sym = 10'b0100111001;
            4'hA:    sym = 10'b0110011100;
            4'hB:    sym = 10'b1011000110;
            4'hC:    sym = 10'b1010001110;
            4'hD:    sym = 10'b1001110001;
            4'hE:    sym = 10'b0101100011;
            default: sym = 10'b1011000011;
        endcase
        return sym;
    endfunction

    // Shared mode pipeline; stage 5 is the output register itself.
    logic [2:0] s1_mode, s2_mode, s3_mode, s4_mode;
    logic       s3_video;

    assign s3_video = (s3_mode == MODE_VIDEO);

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's value from before this clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_mode  <= MODE_CTRL;
            s2_mode  <= MODE_CTRL;
            s3_mode  <= MODE_CTRL;
            s4_mode  <= MODE_CTRL;
            out_mode <= MODE_CTRL;
            out_err  <= 1'b0;
        end else if (cke) begin
            s1_mode  <= in_mode;
            s2_mode  <= s1_mode;
            s3_mode  <= s2_mode;
            s4_mode  <= s3_mode;
            out_mode <= s4_mode;
            if (s4_mode > MODE_DI_GB) begin
                out_err <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        localparam int LANE_MOD = i % 3;

        logic [7:0] d_lane;
        logic [1:0] c_lane;
        logic [3:0] aux_lane;

        assign d_lane   = in_d[8*i +: 8];
        assign c_lane   = in_c[2*i +: 2];
        assign aux_lane = in_aux[4*i +: 4];

        logic [3:0]        ones_d;
        logic              use_xnor;
        logic [9:0]        side_sym;
        logic [8:0]        qm_nxt;
        logic [3:0]        ones_qm;
        logic [9:0]        vid_sym;
        logic signed [4:0] cnt_nxt;
        logic signed [4:0] two_qm8;
        logic signed [4:0] two_nqm8;

        logic [7:0]        s1_d;
        logic              s1_xnor;
        logic [9:0]        s1_sym;
        logic [8:0]        s2_qm;
        logic [9:0]        s2_sym;
        logic [8:0]        s3_qm;
        logic signed [4:0] s3_n;
        logic [9:0]        s3_sym;
        logic [9:0]        s4_sym;
        logic signed [4:0] cnt;
        logic [9:0]        sym_q;

        // Stage 1: transition-minimising choice (xnor vs xor).
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        always_comb begin
            ones_d = '0;
            for (int b = 0; b < 8; b++) begin
                ones_d = ones_d + 4'(d_lane[b]);
            end
            use_xnor = (ones_d > 4'd4) || ((ones_d == 4'd4) && !d_lane[0]);
        end

        // Non-video symbol is resolved up front and carried down the pipe;
        // a DVI-only build falls back to the control code for HDMI modes.
        always_comb begin
            side_sym = ctrl_code(c_lane);
            if (HDMI_EN != 0) begin
                case (in_mode)
                    MODE_DI:     side_sym = terc4_code(aux_lane);
                    MODE_VID_GB: side_sym = (LANE_MOD == 1) ? GB_B : GB_A;
                    MODE_DI_GB:  side_sym = (LANE_MOD == 0) ? terc4_code(aux_lane) : GB_B;
                    default:     side_sym = ctrl_code(c_lane);
                endcase
            end
        end

        // Stage 2: q_m chain; q_m[8] records xor (1) or xnor (0).
        always_comb begin
            qm_nxt    = '0;
            qm_nxt[0] = s1_d[0];
            for (int b = 1; b < 8; b++) begin
                qm_nxt[b] = s1_xnor ? ~(qm_nxt[b-1] ^ s1_d[b]) : (qm_nxt[b-1] ^ s1_d[b]);
            end
            qm_nxt[8] = ~s1_xnor;
        end

        // Stage 3: ones in q_m[7:0]; disparity n = 2*ones - 8.
        always_comb begin
            ones_qm = '0;
            for (int b = 0; b < 8; b++) begin
                ones_qm = ones_qm + 4'(s2_qm[b]);
            end
        end

        // Stage 4: DC balance against the running disparity of this lane.
        always_comb begin
            two_qm8  = s3_qm[8] ? 5'sd2 : 5'sd0;
            two_nqm8 = s3_qm[8] ? 5'sd0 : 5'sd2;
            vid_sym  = '0;
            cnt_nxt  = cnt;
            if ((cnt == 5'sd0) || (s3_n == 5'sd0)) begin
                vid_sym = {~s3_qm[8], s3_qm[8], s3_qm[8] ? s3_qm[7:0] : ~s3_qm[7:0]};
                cnt_nxt = s3_qm[8] ? (cnt + s3_n) : (cnt - s3_n);
            end else if (cnt[4] == s3_n[4]) begin
                // Both nonzero here, so equal sign bits mean equal signs.
                vid_sym = {1'b1, s3_qm[8], ~s3_qm[7:0]};
                cnt_nxt = cnt + two_qm8 - s3_n;
            end else begin
                vid_sym = {1'b0, s3_qm[8], s3_qm[7:0]};
                cnt_nxt = cnt - two_nqm8 + s3_n;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1_d    <= '0;
                s1_xnor <= 1'b0;
                s1_sym  <= CTRL_00;
                s2_qm   <= '0;
                s2_sym  <= CTRL_00;
                s3_qm   <= '0;
                s3_n    <= '0;
                s3_sym  <= CTRL_00;
                s4_sym  <= CTRL_00;
                cnt     <= '0;
                sym_q   <= CTRL_00;
            end else if (cke) begin
                s1_d    <= d_lane;
                s1_xnor <= use_xnor;
                s1_sym  <= side_sym;
                s2_qm   <= qm_nxt;
                s2_sym  <= s1_sym;
                s3_qm   <= s2_qm;
                s3_n    <= $signed({ones_qm, 1'b0} - 5'd8);
                s3_sym  <= s2_sym;
                // Any non-video symbol clears the disparity, so each video
                // period starts balanced.
                s4_sym  <= s3_video ? vid_sym : s3_sym;
                cnt     <= s3_video ? cnt_nxt : 5'sd0;
                sym_q   <= s4_sym;
            end
        end

        assign out_d[10*i +: 10] = sym_q;
    end

endmodule

// File: tb/tb_hdmi_tx_encode_multi.sv
// ---------------------------------------------------------------------------
// tb_hdmi_tx_encode_multi
//   Directed bench for hdmi_tx_encode_multi. Two 3-lane instances share all
//   inputs: one HDMI build and one DVI-only build. Each vector carries its
//   hand-computed expected symbols; a scoreboard queue lines them up with
//   the five-stage output latency.
// ---------------------------------------------------------------------------
module tb_hdmi_tx_encode_multi;

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;
    localparam logic [9:0] GBA = 10'b1011001100;
    localparam logic [9:0] GBB = 10'b0100110011;

    localparam logic [9:0] TERC4 [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    // Video burst: lane0 d=0x00, lane1 d=0xFF, lane2 d=0x10 starting at cnt=0.
    localparam logic [9:0] L0_BURST [10] = '{
        10'h100, 10'h3FF, 10'h100, 10'h3FF, 10'h100,
        10'h3FF, 10'h100, 10'h3FF, 10'h100, 10'h100
    };
    localparam logic [9:0] L1_BURST [10] = '{
        10'h200, 10'h0FF, 10'h0FF, 10'h200, 10'h0FF,
        10'h200, 10'h0FF, 10'h200, 10'h0FF, 10'h0FF
    };
    localparam logic [9:0] L2_VID = 10'h1F0;
    localparam logic [23:0] VD = {8'h10, 8'hFF, 8'h00};

    localparam logic [2:0] M_CTRL  = 3'd0;
    localparam logic [2:0] M_VIDEO = 3'd1;
    localparam logic [2:0] M_DI    = 3'd2;
    localparam logic [2:0] M_VIDGB = 3'd3;
    localparam logic [2:0] M_DIGB  = 3'd4;

    logic        clk;
    logic        reset;
    logic        cke;
    logic [2:0]  in_mode;
    logic [23:0] in_d;
    logic [5:0]  in_c;
    logic [11:0] in_aux;
    logic [29:0] out_d, out_d_dvi;
    logic [2:0]  out_mode, out_mode_dvi;
    logic        out_err, out_err_dvi;

    hdmi_tx_encode_multi #(.NUM_CH(3), .HDMI_EN(1)) dut_hdmi (
        .clk(clk), .reset(reset), .cke(cke), .in_mode(in_mode),
        .in_d(in_d), .in_c(in_c), .in_aux(in_aux),
        .out_d(out_d), .out_mode(out_mode), .out_err(out_err)
    );

    hdmi_tx_encode_multi #(.NUM_CH(3), .HDMI_EN(0)) dut_dvi (
        .clk(clk), .reset(reset), .cke(cke), .in_mode(in_mode),
        .in_d(in_d), .in_c(in_c), .in_aux(in_aux),
        .out_d(out_d_dvi), .out_mode(out_mode_dvi), .out_err(out_err_dvi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       tag;
        logic [2:0]  mode;
        logic [29:0] exp_d;
        logic [29:0] exp_d0;
    } entry_t;

    entry_t      sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        model_err;
    logic [29:0] last_d;
    bit          rand_cke;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
        case (c)
            2'b00:   return C00;
            2'b01:   return C01;
            2'b10:   return C10;
            default: return C11;
        endcase
    endfunction

    // Apply one vector for one cke-qualified clock and compare the vector
    // that entered the pipe five advances earlier.
    task automatic send(input string tag, input logic [2:0] mode, input logic [23:0] d,
                        input logic [5:0] c, input logic [11:0] aux, input logic [29:0] exp);
        entry_t e;
        e.tag   = tag;
        e.mode  = mode;
        e.exp_d = exp;
        if (mode >= M_DI && mode <= M_DIGB)
            e.exp_d0 = {ctrl_sym(c[5:4]), ctrl_sym(c[3:2]), ctrl_sym(c[1:0])};
        else
            e.exp_d0 = exp;
        sb.push_back(e);
        if (rand_cke) begin
            int gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
                cke     = 1'b0;
                in_mode = 3'($urandom_range(0, 7));
                in_d    = 24'($urandom);
                in_c    = 6'($urandom);
                in_aux  = 12'($urandom);
                @(posedge clk); #1;
                check({tag, "/hold"}, 32'(out_d), 32'(last_d));
            end
        end
        cke     = 1'b1;
        in_mode = mode;
        in_d    = d;
        in_c    = c;
        in_aux  = aux;
        @(posedge clk); #1;
        if (sb.size() == 5) begin
            e = sb.pop_front();
            if (e.mode > M_DIGB) model_err = 1'b1;
            check({e.tag, "/d"},       32'(out_d),        32'(e.exp_d));
            check({e.tag, "/mode"},    32'(out_mode),     32'(e.mode));
            check({e.tag, "/err"},     32'(out_err),      32'(model_err));
            check({e.tag, "/dvi_d"},   32'(out_d_dvi),    32'(e.exp_d0));
            check({e.tag, "/dvi_mode"}, 32'(out_mode_dvi), 32'(e.mode));
            check({e.tag, "/dvi_err"}, 32'(out_err_dvi),  32'(model_err));
            last_d = e.exp_d;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) send("idle", M_CTRL, 24'h0, 6'h0, 12'h0, {3{C00}});
    endtask

    initial begin
        reset     = 1'b0;
        cke       = 1'b1;
        in_mode   = M_CTRL;
        in_d      = '0;
        in_c      = '0;
        in_aux    = '0;
        rand_cke  = 1'b0;
        model_err = 1'b0;
        last_d    = {3{C00}};

        // Power-on reset state.
        #2 reset = 1'b1;
        #5;
        check("rst/d",    32'(out_d),    32'({3{C00}}));
        check("rst/mode", 32'(out_mode), 32'(0));
        check("rst/err",  32'(out_err),  32'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        idle(5);

        // Control code sweep on every lane.
        send("ctrl00", M_CTRL, 24'h0, 6'b000000, 12'h0, {3{C00}});
        send("ctrl01", M_CTRL, 24'h0, 6'b010101, 12'h0, {3{C01}});
        send("ctrl10", M_CTRL, 24'h0, 6'b101010, 12'h0, {3{C10}});
        send("ctrl11", M_CTRL, 24'h0, 6'b111111, 12'h0, {3{C11}});

        // One video symbol, a control cycle, then a video burst from cnt=0.
        send("vid_first", M_VIDEO, VD, 6'h0, 12'h0, {L2_VID, L1_BURST[0], L0_BURST[0]});
        send("vid_break", M_CTRL, 24'h0, 6'h0, 12'h0, {3{C00}});
        for (int k = 0; k < 10; k++)
            send($sformatf("vid_burst%0d", k), M_VIDEO, VD, 6'h0, 12'h0,
                 {L2_VID, L1_BURST[k], L0_BURST[k]});
        send("vid_break2", M_CTRL, 24'h0, 6'h0, 12'h0, {3{C00}});
        // lane0 0x1E: four ones with d[0]=0 takes the xnor path.
        send("vid_1e", M_VIDEO, {8'h10, 8'hFF, 8'h1E}, 6'h0, 12'h0, {L2_VID, 10'h200, 10'h25F});
        send("vid_1e_next", M_VIDEO, VD, 6'h0, 12'h0, {L2_VID, 10'h0FF, 10'h100});

        // Data island: each lane gets a different nibble.
        for (int n = 0; n < 16; n++) begin
            logic [3:0] n0, n1, n2;
            n0 = 4'(n);
            n1 = 4'(n + 1);
            n2 = 4'(n + 5);
            send($sformatf("di%0d", n), M_DI, 24'h0, 6'b101010, {n2, n1, n0},
                 {TERC4[n2], TERC4[n1], TERC4[n0]});
        end

        send("vid_gb", M_VIDGB, 24'h0, 6'b010101, 12'h0, {GBA, GBB, GBA});
        send("di_gb", M_DIGB, 24'h0, 6'b111111, {4'h3, 4'h3, 4'hC}, {GBB, GBB, TERC4[12]});
        idle(5);

        // Same video burst with cke stalls and garbage inputs while stalled.
        rand_cke = 1'b1;
        for (int k = 0; k < 10; k++)
            send($sformatf("cke_burst%0d", k), M_VIDEO, VD, 6'h0, 12'h0,
                 {L2_VID, L1_BURST[k], L0_BURST[k]});
        idle(5);
        rand_cke = 1'b0;

        // Illegal mode: control code output and sticky error.
        send("mode6", 3'd6, 24'h0, 6'b010101, 12'h0, {3{C01}});
        idle(6);

        // Reset in the middle of video must clear outputs without a clock.
        for (int k = 0; k < 6; k++)
            send($sformatf("pre_rst%0d", k), M_VIDEO, VD, 6'h0, 12'h0,
                 {L2_VID, L1_BURST[k], L0_BURST[k]});
        reset = 1'b1;
        #2;
        check("rst_mid/d",    32'(out_d),    32'({3{C00}}));
        check("rst_mid/mode", 32'(out_mode), 32'(0));
        check("rst_mid/err",  32'(out_err),  32'(0));
        reset = 1'b0;
        sb.delete();
        model_err = 1'b0;
        last_d    = {3{C00}};
        send("post_rst_v0", M_VIDEO, VD, 6'h0, 12'h0, {L2_VID, L1_BURST[0], L0_BURST[0]});
        send("post_rst_v1", M_VIDEO, VD, 6'h0, 12'h0, {L2_VID, L1_BURST[1], L0_BURST[1]});
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
